// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL register layouts and serializer state encodings.
package uart_tx_mmio_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [2:0]  rsvd_lo;
        logic        overflow;
        logic        irq_pending;
        logic        busy;
        logic        full;
        logic        empty;
    } status_t;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        irq_en;
        logic        tx_en;
    } ctrl_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide TX FIFO; the caller qualifies i_push (never push when full
// without a same-cycle pop) and i_pop (never pop when empty).
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [7:0]            i_din,
    output logic [7:0]            o_dout_c,
    output logic                  o_empty_c,
    output logic                  o_full_c,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout_c  = r_mem[r_rptr];
    assign o_empty_c = (r_count == '0);
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/CTRL registers,
// TX FIFO and serializer. Define UART_TX_IRQ_EN to build the TX-done interrupt.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0040,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irqout
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    tx_state_t     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_tx_en;
    logic          r_overflow;

    logic          w_hit;
    logic          w_wr_tx;
    logic          w_wr_st;
    logic          w_wr_ctrl;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic [7:0]    w_dout;
    logic          w_stop_end;
    logic          w_irq_pend_rd;
    logic          w_irq_en_rd;
    status_t       w_wstat;
    ctrl_t         w_wctrl;
    status_t       w_status;
    ctrl_t         w_ctrl;
    logic          w_unused;

    assign w_hit = (addr[31:4] == BASE_ADDR[31:4]) &&
                   (addr[3:0] inside {OFF_TXDATA, OFF_STATUS, OFF_CTRL});
    assign w_wr_tx   = wr && w_hit && (addr[3:0] == OFF_TXDATA);
    assign w_wr_st   = wr && w_hit && (addr[3:0] == OFF_STATUS);
    assign w_wr_ctrl = wr && w_hit && (addr[3:0] == OFF_CTRL);
    assign w_wstat   = status_t'(wdata);
    assign w_wctrl   = ctrl_t'(wdata);
    assign w_unused  = ^{w_wstat, w_wctrl};

    assign w_pop      = (r_state == ST_IDLE) && r_tx_en && !w_empty;
    assign w_push_ok  = w_wr_tx && (!w_full || w_pop);
    assign w_stop_end = (r_state == ST_STOP) && (r_baud == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push_ok),
        .i_pop     (w_pop),
        .i_din     (wdata[7:0]),
        .o_dout_c  (w_dout),
        .o_empty_c (w_empty),
        .o_full_c  (w_full),
        .o_count   (w_count)
    );

    // Control and sticky overflow; a dropped push beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_en    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_tx_en <= w_wctrl.tx_en;
            end
            if (w_wr_tx && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (w_wr_st && w_wstat.overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Serializer; the line register follows the state one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_dout;
                        r_baud  <= BAUD_RELOAD;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                ST_DATA: begin
                    r_tx <= r_shift[r_bit];
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        r_bit  <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_tx <= 1'b1;
                    if (r_baud == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic r_irq_pending;
    logic r_irq_en;
    logic r_irqout;
    logic w_irq_pend_nxt;
    logic w_irq_en_nxt;

    // Set at the end of the last queued frame; set wins over W1C.
    assign w_irq_pend_nxt = (w_stop_end && w_empty) ? 1'b1 :
                            (w_wr_st && w_wstat.irq_pending) ? 1'b0 : r_irq_pending;
    assign w_irq_en_nxt   = w_wr_ctrl ? w_wctrl.irq_en : r_irq_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_pending <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irqout      <= 1'b0;
        end else begin
            r_irq_pending <= w_irq_pend_nxt;
            r_irq_en      <= w_irq_en_nxt;
            r_irqout      <= w_irq_pend_nxt & w_irq_en_nxt;
        end
    end

    assign w_irq_pend_rd = r_irq_pending;
    assign w_irq_en_rd   = r_irq_en;
    assign irqout        = r_irqout;
`else
    assign w_irq_pend_rd = 1'b0;
    assign w_irq_en_rd   = 1'b0;
    assign irqout        = 1'b0;
`endif

    always_comb begin
        w_status             = '0;
        w_status.count       = 8'(w_count);
        w_status.overflow    = r_overflow;
        w_status.irq_pending = w_irq_pend_rd;
        w_status.busy        = (r_state != ST_IDLE);
        w_status.full        = w_full;
        w_status.empty       = w_empty;
        w_ctrl               = '0;
        w_ctrl.tx_en         = r_tx_en;
        w_ctrl.irq_en        = w_irq_en_rd;
    end

    always_comb begin
        rdata = '0;
        if (rd && w_hit) begin
            case (addr[3:0])
                OFF_STATUS: rdata = w_status;
                OFF_CTRL:   rdata = w_ctrl;
                default:    rdata = '0;
            endcase
        end
    end

    assign uart_tx = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus-driven stimulus, a line monitor decoding 8N1
// frames into a receive queue, and a scoreboard of expected bytes.
module tb_uart_tx_mmio;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB + 1;
    localparam logic [31:0] BASE      = 32'h4000_0040;
    localparam logic [31:0] ADDR_TX   = BASE;
    localparam logic [31:0] ADDR_ST   = BASE + 32'd4;
    localparam logic [31:0] ADDR_CTRL = BASE + 32'd8;
`ifdef UART_TX_IRQ_EN
    localparam logic [31:0] IRQ_BIT = 32'h8;
`else
    localparam logic [31:0] IRQ_BIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        irqout;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         start_cyc;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    bit         m_busy = 0;
    int         m_cnt = 0;
    int         m_start = 0;
    logic [7:0] m_data = '0;
    rx_t        m_frame;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_tx (uart_tx),
        .irqout  (irqout)
    );

    always #5 clk = ~clk;

    // Line monitor: samples mid-bit, frames are timed from the first low sample.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (uart_tx === 1'b0) begin
                m_busy  = 1;
                m_cnt   = 0;
                m_start = cyc;
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == CPB / 2 && uart_tx !== 1'b0) begin
                m_busy = 0;
            end else if (m_cnt >= CPB + CPB / 2 && m_cnt <= 8 * CPB + CPB / 2 && (m_cnt % CPB) == CPB / 2) begin
                m_data[(m_cnt - CPB - CPB / 2) / CPB] = uart_tx;
            end else if (m_cnt == 9 * CPB + CPB / 2) begin
                m_frame.data      = m_data;
                m_frame.stop_ok   = (uart_tx === 1'b1);
                m_frame.start_cyc = m_start;
                rx_q.push_back(m_frame);
                m_busy = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1;
        addr = a;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
        addr = '0;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1;
        addr = a;
        #1;
        d = rdata;
        rd = 1'b0;
        addr = '0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        bus_write(ADDR_TX, {24'h0, b});
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_total++;
        if (uart_tx !== 1'b1 || irqout !== 1'b0) $display("FAIL reset_lines: uart_tx=%b irqout=%b, required 1 and 0", uart_tx, irqout);
        else n_pass++;
        reset = 1'b1;
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL reset_status: got %h, required 00000001", d);
        else n_pass++;
        bus_read(ADDR_CTRL, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL reset_ctrl: got %h, required 00000000", d);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [31:0] d;
        bus_write(BASE + 32'h10, 32'h3);
        bus_write(BASE + 32'h10, 32'h77);
        bus_read(ADDR_CTRL, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL decode_miss_write: CTRL got %h, required 00000000", d);
        else n_pass++;
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL decode_miss_push: STATUS got %h, required 00000001", d);
        else n_pass++;
        bus_read(BASE + 32'hC, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL decode_miss_read: got %h, required 00000000", d);
        else n_pass++;
        @(negedge clk);
        addr = ADDR_ST;
        #1;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL read_without_rd: got %h, required 00000000", rdata);
        else n_pass++;
        addr = '0;
        bus_write(ADDR_CTRL, 32'hFFFF_FFF1);
        bus_read(ADDR_CTRL, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL ctrl_readback: got %h, required 00000001", d);
        else n_pass++;
        bus_read(ADDR_TX, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL txdata_read: got %h, required 00000000", d);
        else n_pass++;
        bus_write(ADDR_CTRL, 32'h0);
    endtask

    task automatic test_single_frame();
        logic [9:0] pat;
        rx_t r;
        logic [7:0] e;
        exp_q.delete();
        rx_q.delete();
        bus_write(ADDR_CTRL, 32'h1);
        push_byte(8'hA5, 1'b1);
        pat = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        n_total++;
        if (uart_tx !== 1'b1) $display("FAIL start_latency: uart_tx=%b one clk after write, required 1", uart_tx);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < int'(CPB); j++) begin
                @(negedge clk);
                n_total++;
                if (uart_tx !== pat[k]) $display("FAIL line_a5 bit %0d cyc %0d: uart_tx=%b, required %b", k, j, uart_tx, pat[k]);
                else n_pass++;
            end
        end
        wait_frames(1, 10);
        n_total++;
        if (rx_q.size() != 1) $display("FAIL a5_frame_count: got %0d frames, required 1", rx_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            n_total++;
            if (r.data !== e || r.stop_ok !== 1'b1) $display("FAIL a5_scoreboard: got %h stop=%b, required %h stop=1", r.data, r.stop_ok, e);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_ST, 32'h18);
        exp_q.delete();
        rx_q.delete();
        for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i), i < 4);
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h0000_0412) $display("FAIL overflow_status: got %h, required 00000412", d);
        else n_pass++;
        bus_write(ADDR_ST, 32'h10);
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h0000_0402) $display("FAIL overflow_w1c: got %h, required 00000402", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        rx_t r;
        logic [7:0] e;
        int prev;
        bus_write(ADDR_CTRL, 32'h1);
        wait_frames(4, 4 * FRAME + 40);
        n_total++;
        if (rx_q.size() != 4) $display("FAIL b2b_frame_count: got %0d frames, required 4", rx_q.size());
        else n_pass++;
        prev = -1;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            n_total++;
            if (r.data !== e || r.stop_ok !== 1'b1) $display("FAIL b2b_scoreboard: got %h stop=%b, required %h stop=1", r.data, r.stop_ok, e);
            else n_pass++;
            if (prev >= 0) begin
                n_total++;
                if (r.start_cyc - prev != int'(FRAME)) $display("FAIL b2b_spacing: got %0d clk, required %0d", r.start_cyc - prev, FRAME);
                else n_pass++;
            end
            prev = r.start_cyc;
        end
        repeat (5) @(negedge clk);
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== (32'h1 | IRQ_BIT)) $display("FAIL b2b_end_status: got %h, required %h", d, 32'h1 | IRQ_BIT);
        else n_pass++;
        bus_write(ADDR_ST, 32'h18);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        rx_t r;
        exp_q.delete();
        rx_q.delete();
        bus_write(ADDR_CTRL, 32'h3);
        push_byte(8'h55, 1'b1);
        n_total++;
        if (irqout !== 1'b0) $display("FAIL irq_early: irqout=%b during frame, required 0", irqout);
        else n_pass++;
        wait_frames(1, FRAME + 20);
        n_total++;
        if (rx_q.size() != 1) $display("FAIL irq_frame_count: got %0d frames, required 1", rx_q.size());
        else n_pass++;
        if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            n_total++;
            if (r.data !== exp_q[0] || r.stop_ok !== 1'b1) $display("FAIL irq_scoreboard: got %h, required %h", r.data, exp_q[0]);
            else n_pass++;
        end
        repeat (4) @(negedge clk);
`ifdef UART_TX_IRQ_EN
        n_total++;
        if (irqout !== 1'b1) $display("FAIL irq_set: irqout=%b after stop bit, required 1", irqout);
        else n_pass++;
        bus_write(ADDR_CTRL, 32'h1);
        n_total++;
        if (irqout !== 1'b0) $display("FAIL irq_mask: irqout=%b with irq_en=0, required 0", irqout);
        else n_pass++;
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h9) $display("FAIL irq_pending_masked: STATUS got %h, required 00000009", d);
        else n_pass++;
        bus_write(ADDR_CTRL, 32'h3);
        n_total++;
        if (irqout !== 1'b1) $display("FAIL irq_unmask: irqout=%b, required 1", irqout);
        else n_pass++;
        bus_write(ADDR_ST, 32'h08);
        n_total++;
        if (irqout !== 1'b0) $display("FAIL irq_w1c: irqout=%b, required 0", irqout);
        else n_pass++;
`else
        n_total++;
        if (irqout !== 1'b0) $display("FAIL irq_absent: irqout=%b, required 0", irqout);
        else n_pass++;
        bus_read(ADDR_CTRL, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL irq_en_absent: CTRL got %h, required 00000001", d);
        else n_pass++;
`endif
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL irq_end_status: got %h, required 00000001", d);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int lows;
        rx_q.delete();
        bus_write(ADDR_CTRL, 32'h1);
        push_byte(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        n_total++;
        if (uart_tx !== 1'b0) $display("FAIL rst_start_bit: uart_tx=%b, required 0", uart_tx);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (uart_tx !== 1'b1) $display("FAIL rst_abort_start: uart_tx=%b, required 1", uart_tx);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_write(ADDR_CTRL, 32'h1);
        push_byte(8'hFF, 1'b0);
        repeat (12) @(negedge clk);
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h5) $display("FAIL rst_busy_data: STATUS got %h, required 00000005", d);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (uart_tx !== 1'b1) $display("FAIL rst_abort_data: uart_tx=%b, required 1", uart_tx);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_read(ADDR_ST, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL rst_status_after: got %h, required 00000001", d);
        else n_pass++;
        bus_write(ADDR_CTRL, 32'h1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        n_total++;
        if (lows != 0 || rx_q.size() != 0) $display("FAIL rst_no_resume: %0d low samples, %0d frames, required 0 and 0", lows, rx_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_irq();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
